// File: rtl/prog_clk_divider_if.sv
// Control and status bundle for prog_clk_divider: run/load requests in,
// divided clock, period tick and load handshake out.
interface prog_clk_divider_if #(
    parameter int WIDTH = 8
);
    logic             en_i;
    logic             load_i;
    logic [WIDTH-1:0] div_i;
    logic             clk_o;
    logic             tick_o;
    logic             load_ack_o;
    logic             pend_o;

    modport master (
        output en_i, load_i, div_i,
        input  clk_o, tick_o, load_ack_o, pend_o
    );

    modport slave (
        input  en_i, load_i, div_i,
        output clk_o, tick_o, load_ack_o, pend_o
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Programmable divided-clock / tick generator. A newly loaded divisor is held
// pending and only takes effect at a period boundary, so clk_o never runts.
module prog_clk_divider #(
    parameter int WIDTH   = 8,
    parameter int DIV_RST = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    prog_clk_divider_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] DIV_RST_V = WIDTH'(DIV_RST);
    localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_flag_q, pend_flag_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] load_val;
    logic             boundary;

    // Divisors below 2 cannot form a high and a low phase, so they are raised to 2.
    assign load_val = (bus.div_i < DIV_MIN) ? DIV_MIN : bus.div_i;

    // Leaving IDLE starts the first period; in RUN the wrap edge ends one.
    assign boundary = bus.en_i && ((state_q == IDLE) || (cnt_q == div_q - WIDTH'(1)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= DIV_RST_V;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && bus.en_i)
            state_d = RUN;
    end

    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        clk_d       = clk_q;
        tick_d      = 1'b0;
        ack_d       = 1'b0;

        if (bus.load_i) begin
            pend_d      = load_val;
            pend_flag_d = 1'b1;
        end

        if (boundary) begin
            cnt_d       = '0;
            tick_d      = 1'b1;
            pend_flag_d = 1'b0;
            // A same-edge request overrides an older pending one.
            if (bus.load_i) begin
                div_d = load_val;
                ack_d = 1'b1;
            end else if (pend_flag_q) begin
                div_d = pend_q;
                ack_d = 1'b1;
            end
        end else if (state_q == RUN && bus.en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        // High while in the first floor(N/2) cycles of the period; frozen when disabled.
        if (boundary || (state_q == RUN && bus.en_i))
            clk_d = (cnt_d < (div_d >> 1));
    end

    assign bus.clk_o      = clk_q;
    assign bus.tick_o     = tick_q;
    assign bus.load_ack_o = ack_q;
    assign bus.pend_o     = pend_flag_q;
endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomised and directed stimulus for prog_clk_divider, checked cycle by cycle
// against a period-level reference model through an expected-output queue.
module tb_prog_clk_divider;
    localparam int W = 8;

    typedef struct {
        logic clk;
        logic tick;
        logic ack;
        logic pend;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] div = '0;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    exp_t exp_q[$];

    // Reference model: whether a period is running, position inside it,
    // current period length, and an optional pending period length.
    bit m_run = 1'b0;
    int m_pos = 0;
    int m_n = 2;
    bit m_pv = 1'b0;
    int m_pval = 0;

    prog_clk_divider_if #(.WIDTH(W)) bus ();

    assign bus.en_i   = en;
    assign bus.load_i = load;
    assign bus.div_i  = div;

    prog_clk_divider #(.WIDTH(W), .DIV_RST(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual %b required %b", name, cycle, act, req);
        end
    endtask

    // Monitor: the DUT presents a fresh output set every cycle; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("clk_o", bus.clk_o, e.clk);
            check("tick_o", bus.tick_o, e.tick);
            check("load_ack_o", bus.load_ack_o, e.ack);
            check("pend_o", bus.pend_o, e.pend);
        end
    end

    function automatic void model(input bit r, input bit e, input bit l, input int d);
        exp_t x;
        int c;
        x = '{1'b0, 1'b0, 1'b0, 1'b0};
        if (r) begin
            m_run = 1'b0;
            m_pos = 0;
            m_n   = 2;
            m_pv  = 1'b0;
        end else begin
            c = (d < 2) ? 2 : d;
            if (e && (!m_run || m_pos == m_n - 1)) begin
                if (l) begin
                    m_n   = c;
                    x.ack = 1'b1;
                end else if (m_pv) begin
                    m_n   = m_pval;
                    x.ack = 1'b1;
                end
                m_pv   = 1'b0;
                m_pos  = 0;
                m_run  = 1'b1;
                x.tick = 1'b1;
            end else begin
                if (m_run && e)
                    m_pos++;
                if (l) begin
                    m_pv   = 1'b1;
                    m_pval = c;
                end
            end
            x.clk  = m_run && (m_pos < m_n / 2);
            x.pend = m_pv;
        end
        exp_q.push_back(x);
    endfunction

    task automatic step(input bit r, input bit e, input bit l, input int d);
        rst  = r;
        en   = e;
        load = l;
        div  = W'(d);
        @(posedge clk);
        model(r, e, l, d & 255);
        cycle++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step(0, 1, 0, 0);
    endtask

    // Advance until the next enabled edge ends a period.
    task automatic to_boundary();
        for (int i = 0; i < 300; i++) begin
            if (!m_run || m_pos == m_n - 1)
                break;
            step(0, 1, 0, 0);
        end
    endtask

    // Advance until the next enabled edge falls inside a period.
    task automatic to_mid();
        for (int i = 0; i < 4; i++) begin
            if (m_run && m_pos != m_n - 1)
                break;
            step(0, 1, 0, 0);
        end
    endtask

    initial begin
        bit r, e, l;
        int d;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Default divisor 2.
        run(8);

        // Mid-period load of 5 at divisor 2.
        to_mid();
        step(0, 1, 1, 5);
        run(14);

        // Load on a boundary, then two back-to-back mid-period loads.
        to_boundary();
        step(0, 1, 1, 4);
        step(0, 1, 1, 6);
        step(0, 1, 1, 3);
        run(12);

        // Clamp of 0 and 1, then the maximum divisor.
        to_mid();
        step(0, 1, 1, 0);
        run(8);
        to_mid();
        step(0, 1, 1, 1);
        run(8);
        to_mid();
        step(0, 1, 1, 255);
        run(520);

        // Enable dropped for 3 cycles with a load pending at divisor 4.
        to_boundary();
        step(0, 1, 1, 4);
        step(0, 1, 1, 3);
        repeat (3) step(0, 0, 0, 0);
        run(10);

        // Reset mid-period with a pending load at divisor 6.
        to_boundary();
        step(0, 1, 1, 6);
        run(2);
        step(0, 1, 1, 5);
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        run(8);

        // Load issued while still in IDLE.
        step(1, 0, 0, 0);
        step(0, 0, 1, 7);
        step(0, 0, 0, 0);
        run(20);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            r = ($urandom % 100) == 0;
            e = ($urandom % 8) != 0;
            l = ($urandom % 6) == 0;
            d = (($urandom % 10) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 12);
            step(r, e, l, d);
        end
        run(4);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d left required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
